// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - miss controller for a write-back, write-allocate, direct-mapped cache
//
// Purpose: a single FSM that serves read and write misses. The dirty-victim
// write-back (LW) overlaps the line fill (LB). Same-line hazards against an
// in-flight fill are resolved by stalling the pipeline.
//
// Optional feature macro: CACHE_CRIT_WORD_EN
//   defined     - early restart: a read miss forwards the critical word and
//                 lets hits to other lines proceed while the fill runs (BG)
//   not defined - CrtWord tied to 0, LB_FirstWord ignored, read misses
//                 stall until the refill completes
//
// Ports:
//   Clk, Rst_n               clock (rising edge), async active-low reset
//   En, RW, Addr             memory-stage access (RW=1 write)
//   C_Miss, C_Dirty          tag-miss and victim-dirty flags from the array
//   Stall                    freeze the pipeline (combinational)
//   R_Enable, W_Enable       processor read / word-write strobes
//   WriteType, Merge         line write from LB, merge pending store word
//   LB_Start, LB_Addr        fill start pulse and line-aligned miss address
//   LB_FirstWord, LB_Done    critical word valid / fill complete
//   LW_Start, LW_Done        victim write-back start pulse / complete
//   CrtWord                  select the LB critical word onto read data
//   Busy, Err                FSM not idle / sticky fill timeout
module cache_miss_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5,
  parameter int INDEX_W  = 7,
  parameter int FILL_TMO = 1023
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              C_Miss,
  input  logic              C_Dirty,
  output logic              Stall,
  output logic              R_Enable,
  output logic              W_Enable,
  output logic              WriteType,
  output logic              Merge,
  output logic              LB_Start,
  input  logic              LB_FirstWord,
  input  logic              LB_Done,
  output logic              LW_Start,
  input  logic              LW_Done,
  output logic [ADDR_W-1:0] LB_Addr,
  output logic              CrtWord,
  output logic              Busy,
  output logic              Err
);

  localparam int LINE_HI = OFFSET_W + INDEX_W - 1;
  localparam int TMO_LAST_I = (FILL_TMO > 0) ? FILL_TMO - 1 : 0;
  localparam logic [9:0] TMO_LAST = 10'(TMO_LAST_I);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
`ifdef CACHE_CRIT_WORD_EN
    S_BG,
`endif
    S_WAITLW,
    S_REFILL
  } state_t;

  state_t      state, state_nxt;
  logic        rw_q;
  logic        lw_pend;
  logic [9:0]  tmo_cnt;
  logic        accept;
  logic        tmo_fire;
  logic        lw_open;
  logic        tmo_hit;
  logic        same_line;

  // Line id comparison against the open miss (BG hazard detection).
  assign same_line = (Addr[LINE_HI:OFFSET_W] == LB_Addr[LINE_HI:OFFSET_W]);
  // A write-back finishing this very cycle counts as already done, so
  // LB_Done/LW_Done coincidences go straight to REFILL.
  assign lw_open   = lw_pend & ~LW_Done;
  assign tmo_hit   = (FILL_TMO != 0) && (tmo_cnt == TMO_LAST);

`ifndef CACHE_CRIT_WORD_EN
  logic unused_first_word;
  assign unused_first_word = LB_FirstWord;
`endif

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    CrtWord   = 1'b0;
    WriteType = 1'b0;
    Merge     = 1'b0;
    accept    = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        // Rst_n qualifies the miss so Stall stays low while in reset.
        if (Rst_n && En && C_Miss) begin
          Stall     = 1'b1;
          accept    = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        Stall = 1'b1;
`ifdef CACHE_CRIT_WORD_EN
        if (!rw_q && LB_FirstWord) begin
          CrtWord = 1'b1;
          Stall   = 1'b0;
        end
`endif
        if (LB_Done) begin
          state_nxt = lw_open ? S_WAITLW : S_REFILL;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
          tmo_fire  = 1'b1;
`ifdef CACHE_CRIT_WORD_EN
        end else if (!rw_q && LB_FirstWord) begin
          state_nxt = S_BG;
`endif
        end
      end
`ifdef CACHE_CRIT_WORD_EN
      S_BG: begin
        Stall = En & (same_line | C_Miss | RW);
        if (LB_Done) begin
          state_nxt = lw_open ? S_WAITLW : S_REFILL;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
          tmo_fire  = 1'b1;
        end
      end
`endif
      S_WAITLW: begin
        Stall = 1'b1;
        if (!lw_open) state_nxt = S_REFILL;
      end
      S_REFILL: begin
        Stall     = 1'b1;
        WriteType = 1'b1;
        Merge     = rw_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign R_Enable = En & ~RW & ~Stall;
  assign W_Enable = En & RW & ~Stall;
  assign Busy     = (state != S_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      LB_Addr  <= '0;
      rw_q     <= 1'b0;
      lw_pend  <= 1'b0;
      tmo_cnt  <= '0;
      Err      <= 1'b0;
      LB_Start <= 1'b0;
      LW_Start <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Start pulses appear together with the latched LB_Addr.
      LB_Start <= accept;
      LW_Start <= accept & C_Dirty;
      if (accept) begin
        LB_Addr <= {Addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        rw_q    <= RW;
        lw_pend <= C_Dirty;
        tmo_cnt <= 10'd1;
      end else begin
        if (LW_Done) lw_pend <= 1'b0;
        if (state == S_FILL
`ifdef CACHE_CRIT_WORD_EN
            || state == S_BG
`endif
           ) tmo_cnt <= tmo_cnt + 10'd1;
      end
      if (tmo_fire) Err <= 1'b1;
    end
  end

endmodule
